// File: rtl/hfusion_pkg.sv
// Shared widths, weight constants and per-stage sideband for the HSSIM fusion blend stream.
package hfusion_pkg;

  // Sideband pixel fields are sized for the widest supported DATA_W; narrower builds zero-extend.
  localparam int unsigned PIX_W_MAX = 16;

  // Per-bit decision values; replicated to WGT_W to form the binary blend weight.
  localparam logic WGT_FUSE = 1'b1;
  localparam logic WGT_NEW  = 1'b0;

  function automatic int unsigned prod_w(int unsigned numr_w, int unsigned deno_w);
    return numr_w + deno_w;
  endfunction

  function automatic int unsigned sum_w(int unsigned data_w);
    return 2 * data_w + 1;
  endfunction

  typedef struct packed {
    logic [PIX_W_MAX-1:0] fuse_pix;
    logic [PIX_W_MAX-1:0] new_pix;
    logic                 sof;
    logic                 eol;
  } sband_t;

endpackage

// File: rtl/hfusion_wsmooth3.sv
// S3 of the blend stream: [1 2 1]/4 horizontal weight smoother with neighbour hold and
// edge replication at row start/end.
module hfusion_wsmooth3
  import hfusion_pkg::*;
#(
  parameter int unsigned WGT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             in_valid_i,
  input  logic [WGT_W-1:0] in_wgt_i,
  input  sband_t           in_sb_i,
  output logic             out_valid_o,
  output logic [WGT_W-1:0] out_wgt_o,
  output sband_t           out_sb_o
);

  localparam int unsigned ACC_W = WGT_W + 2;

  logic             c_valid_q;
  logic [WGT_W-1:0] c_wgt_q;
  sband_t           c_sb_q;
  logic             l_valid_q;
  logic [WGT_W-1:0] l_wgt_q;

  logic             fire;
  logic [WGT_W-1:0] wl;
  logic [WGT_W-1:0] wr;
  logic [ACC_W-1:0] acc;

  always_comb begin
    // The right neighbour is whatever S2 holds; an eol centre needs no neighbour.
    out_valid_o = c_valid_q && (in_valid_i || c_sb_q.eol);
    fire        = en_i && out_valid_o;
    wl          = l_valid_q ? l_wgt_q : c_wgt_q;
    wr          = c_sb_q.eol ? c_wgt_q : in_wgt_i;
    acc         = ACC_W'(wl) + (ACC_W'(c_wgt_q) << 1) + ACC_W'(wr);
    out_wgt_o   = WGT_W'(acc >> 2);
    out_sb_o    = c_sb_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_valid_q <= 1'b0;
      c_wgt_q   <= '0;
      c_sb_q    <= '0;
      l_valid_q <= 1'b0;
      l_wgt_q   <= '0;
    end else if (en_i) begin
      // A valid S2 beat can only be present when the centre is empty or leaving.
      if (in_valid_i) begin
        c_valid_q <= 1'b1;
        c_wgt_q   <= in_wgt_i;
        c_sb_q    <= in_sb_i;
      end else if (fire) begin
        c_valid_q <= 1'b0;
      end
      if (fire) begin
        l_wgt_q   <= c_wgt_q;
        l_valid_q <= !c_sb_q.eol;
      end
    end
  end

endmodule

// File: rtl/hfusion_blend_stream.sv
// Streaming HSSIM decision, weight smoothing and blend stage with frame tracking.
// Build option: define HFUSION_ROUND_EN for round-to-nearest with saturation in S4.
module hfusion_blend_stream
  import hfusion_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned WGT_W      = 8,
  parameter int unsigned NUMR_W     = 35,
  parameter int unsigned DENO_W     = 31,
  parameter int unsigned IM_LEN     = 520,
  parameter int unsigned IM_WID     = 520,
  parameter int unsigned NUM_IMAGES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_fuse,
  input  logic [DATA_W-1:0]             s_new,
  input  logic [NUMR_W-1:0]             s_fuse_numr,
  input  logic [DENO_W-1:0]             s_fuse_deno,
  input  logic [NUMR_W-1:0]             s_new_numr,
  input  logic [DENO_W-1:0]             s_new_deno,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_W-1:0]             m_pix,
  output logic                          m_sof,
  output logic                          m_eol,
  output logic [$clog2(NUM_IMAGES)-1:0] img_idx,
  output logic                          frame_done
);

  localparam int unsigned PROD_W = prod_w(NUMR_W, DENO_W);
  localparam int unsigned SUM_W  = sum_w(DATA_W);
  localparam int unsigned IDX_W  = $clog2(NUM_IMAGES);
  localparam int unsigned COL_W  = $clog2(IM_LEN);
  localparam int unsigned ROW_W  = $clog2(IM_WID);

  logic en, acc;
  logic m_valid_q, m_sof_q, m_eol_q;
  logic [DATA_W-1:0] m_pix_q;

  assign en      = !m_valid_q || m_ready;
  assign s_ready = en;
  assign acc     = s_valid && en;

  // Input position counters.
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic in_sof, in_eol;

  assign in_eol = (col_q == COL_W'(IM_LEN - 1));
  assign in_sof = (col_q == '0) && (row_q == '0);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (acc) begin
      if (in_eol) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IM_WID - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // S1: cross-multiply the two HSSIM ratios.
  logic                     s1_valid_q, s1_flip_q;
  logic signed [PROD_W-1:0] s1_pa_q, s1_pb_q;
  sband_t                   s1_sb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_flip_q  <= 1'b0;
      s1_pa_q    <= '0;
      s1_pb_q    <= '0;
      s1_sb_q    <= '0;
    end else if (en) begin
      s1_valid_q <= s_valid;
      if (s_valid) begin
        s1_pa_q   <= $signed(s_fuse_numr) * $signed(s_new_deno);
        s1_pb_q   <= $signed(s_new_numr) * $signed(s_fuse_deno);
        s1_flip_q <= s_fuse_deno[DENO_W-1] ^ s_new_deno[DENO_W-1];
        s1_sb_q   <= '{fuse_pix: PIX_W_MAX'(s_fuse), new_pix: PIX_W_MAX'(s_new),
                       sof: in_sof, eol: in_eol};
      end
    end
  end

  // S2: decide. Opposite denominator signs invert the cross-multiplied comparison.
  logic             s2_valid_q;
  logic [WGT_W-1:0] s2_wgt_q;
  sband_t           s2_sb_q;
  logic             s1_dec;

  assign s1_dec = (s1_pa_q > s1_pb_q) ^ s1_flip_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_wgt_q   <= '0;
      s2_sb_q    <= '0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_wgt_q <= s1_dec ? {WGT_W{WGT_FUSE}} : {WGT_W{WGT_NEW}};
        s2_sb_q  <= s1_sb_q;
      end
    end
  end

  // S3: smoothing.
  logic             s3_valid;
  logic [WGT_W-1:0] s3_wgt;
  sband_t           s3_sb;

  hfusion_wsmooth3 #(
    .WGT_W (WGT_W)
  ) u_wsmooth3 (
    .clk_i       (clk),
    .rst_ni      (rst),
    .en_i        (en),
    .in_valid_i  (s2_valid_q),
    .in_wgt_i    (s2_wgt_q),
    .in_sb_i     (s2_sb_q),
    .out_valid_o (s3_valid),
    .out_wgt_o   (s3_wgt),
    .out_sb_o    (s3_sb)
  );

  // Output-side frame tracking.
  logic [ROW_W-1:0] orow_q;
  logic [IDX_W-1:0] img_idx_q, img_idx_d;
  logic             frame_done_q, out_hs, last_out;

  assign out_hs    = m_valid_q && m_ready;
  assign last_out  = out_hs && m_eol_q && (orow_q == ROW_W'(IM_WID - 1));
  // A beat loaded alongside the last pixel's handshake belongs to the next image.
  assign img_idx_d = last_out ? img_idx_q + IDX_W'(1) : img_idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      orow_q       <= '0;
      img_idx_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      img_idx_q    <= img_idx_d;
      frame_done_q <= last_out;
      if (out_hs && m_eol_q) begin
        orow_q <= last_out ? '0 : orow_q + ROW_W'(1);
      end
    end
  end

  // S4: blend.
  logic [DATA_W-1:0] fuse4, new4, pix_d;
  logic [WGT_W-1:0]  wn4;
  logic [SUM_W-1:0]  sum4, shf4;

  always_comb begin
    fuse4 = DATA_W'(s3_sb.fuse_pix);
    new4  = DATA_W'(s3_sb.new_pix);
    wn4   = ~s3_wgt;
    sum4  = SUM_W'(s3_wgt) * SUM_W'(fuse4) + SUM_W'(wn4) * SUM_W'(new4);
`ifdef HFUSION_ROUND_EN
    shf4  = (sum4 + (SUM_W'(1) << (WGT_W - 1))) >> WGT_W;
    pix_d = (shf4 > SUM_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : DATA_W'(shf4);
`else
    shf4  = sum4 >> WGT_W;
    pix_d = DATA_W'(shf4);
`endif
    if (img_idx_d == '0) begin
      pix_d = new4;
    end else if (sum4 == '0) begin
      pix_d = fuse4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_q <= 1'b0;
      m_pix_q   <= '0;
      m_sof_q   <= 1'b0;
      m_eol_q   <= 1'b0;
    end else if (en) begin
      m_valid_q <= s3_valid;
      if (s3_valid) begin
        m_pix_q <= pix_d;
        m_sof_q <= s3_sb.sof;
        m_eol_q <= s3_sb.eol;
      end
    end
  end

  assign m_valid    = m_valid_q;
  assign m_pix      = m_pix_q;
  assign m_sof      = m_sof_q;
  assign m_eol      = m_eol_q;
  assign img_idx    = img_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hfusion_blend_stream.sv
// Scoreboard bench for hfusion_blend_stream on a 4x2 frame; expected beats are queued at issue.
`timescale 1ns/1ps
module tb_hfusion_blend_stream;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned WGT_W      = 8;
  localparam int unsigned NUMR_W     = 35;
  localparam int unsigned DENO_W     = 31;
  localparam int unsigned IM_LEN     = 4;
  localparam int unsigned IM_WID     = 2;
  localparam int unsigned NUM_IMAGES = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_fuse = '0;
  logic [DATA_W-1:0] s_new = '0;
  logic [NUMR_W-1:0] s_fuse_numr = '0;
  logic [DENO_W-1:0] s_fuse_deno = '0;
  logic [NUMR_W-1:0] s_new_numr = '0;
  logic [DENO_W-1:0] s_new_deno = '0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [DATA_W-1:0] m_pix;
  logic              m_sof, m_eol;
  logic [3:0]        img_idx;
  logic              frame_done;

  always #5 clk = ~clk;

  hfusion_blend_stream #(
    .DATA_W     (DATA_W),
    .WGT_W      (WGT_W),
    .NUMR_W     (NUMR_W),
    .DENO_W     (DENO_W),
    .IM_LEN     (IM_LEN),
    .IM_WID     (IM_WID),
    .NUM_IMAGES (NUM_IMAGES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_fuse      (s_fuse),
    .s_new       (s_new),
    .s_fuse_numr (s_fuse_numr),
    .s_fuse_deno (s_fuse_deno),
    .s_new_numr  (s_new_numr),
    .s_new_deno  (s_new_deno),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_pix       (m_pix),
    .m_sof       (m_sof),
    .m_eol       (m_eol),
    .img_idx     (img_idx),
    .frame_done  (frame_done)
  );

  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       rand_ready = 1'b0;
  int         fd_count = 0;
  int         out_img = 0;
  int         bimg = 0;
  int         brow = 0;
  logic [7:0] rf[4];
  logic [7:0] rn[4];
  int         rm[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Weight w picks fuse with w/255 and new with (255-w)/255.
  function automatic logic [7:0] blend(input int w, input logic [7:0] f, input logic [7:0] n,
                                       input int img);
    int s;
    s = w * int'(f) + (255 - w) * int'(n);
    if (img == 0) return n;
    if (s == 0) return f;
`ifdef HFUSION_ROUND_EN
    s = (s + 128) >> 8;
    if (s > 255) s = 255;
`else
    s = s >> 8;
`endif
    return 8'(s);
  endfunction

  // Downstream ready: always 1 unless random mode is on.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  initial begin
    logic stall_q;
    exp_t held, e;
    stall_q = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) check("stall_hold", {m_valid, m_pix, m_sof, m_eol}, {1'b1, held});
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got pix %0h sof %0b eol %0b, want no beat",
                     m_pix, m_sof, m_eol);
          end else begin
            e = exp_q.pop_front();
            check("beat", {m_pix, m_sof, m_eol}, e);
          end
        end
        stall_q = m_valid && !m_ready;
        held    = {m_pix, m_sof, m_eol};
        if (frame_done) begin
          fd_count++;
          out_img = (out_img + 1) % 16;
          check("img_idx_step", img_idx, out_img);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input int i);
    logic hs;
    int   guard;
    s_valid = 1'b1;
    s_fuse  = rf[i];
    s_new   = rn[i];
    case (rm[i])
      1: begin
        s_fuse_numr = 35'sd10; s_fuse_deno = 31'sd1; s_new_numr = 35'sd1; s_new_deno = 31'sd1;
      end
      2: begin
        s_fuse_numr = 35'sd5; s_fuse_deno = -31'sd1; s_new_numr = 35'sd5; s_new_deno = 31'sd1;
      end
      default: begin
        s_fuse_numr = 35'sd1; s_fuse_deno = 31'sd1; s_new_numr = 35'sd10; s_new_deno = 31'sd1;
      end
    endcase
    guard = 0;
    forever begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk);
      #1;
      if (hs) break;
      guard++;
      if (guard > 200) begin
        checks++;
        errors++;
        $display("FAIL s_ready_timeout: got s_ready 0 for %0d cycles, want 1", guard);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  // Mode 1 means fuse wins; modes 0 and 2 (sign flip) mean new wins.
  task automatic send_row(input int nsend, input bit gaps);
    int   dw[4];
    int   wl, wr, ws;
    exp_t e;
    for (int i = 0; i < 4; i++) dw[i] = (rm[i] == 1) ? 255 : 0;
    for (int i = 0; i < 4; i++) begin
      wl    = (i == 0) ? dw[i] : dw[i-1];
      wr    = (i == 3) ? dw[i] : dw[i+1];
      ws    = (wl + 2 * dw[i] + wr) >> 2;
      e.pix = blend(ws, rf[i], rn[i], bimg);
      e.sof = (brow == 0) && (i == 0);
      e.eol = (i == 3);
      exp_q.push_back(e);
    end
    for (int i = 0; i < nsend; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send_beat(i);
    end
    if (nsend == 4) begin
      brow++;
      if (brow == IM_WID) begin
        brow = 0;
        bimg = (bimg + 1) % 16;
      end
    end
  endtask

  task automatic fill(input logic [7:0] f, input logic [7:0] n, input int m);
    for (int i = 0; i < 4; i++) begin
      rf[i] = f;
      rn[i] = n;
      rm[i] = m;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 4; i++) begin
      rf[i] = 8'($urandom);
      rn[i] = 8'($urandom);
      rm[i] = $urandom_range(0, 2);
    end
  endtask

  task automatic drain(input string name, input int bound);
    int n;
    rand_ready = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < bound) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle(3);
    check("rst_m_valid", m_valid, 0);
    check("rst_img_idx", img_idx, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_m_pix", m_pix, 0);
    rst = 1'b1;
    idle(1);
    check("s_ready_after_rst", s_ready, 1);

    // Image 0: pass-through of new pixels.
    for (int r = 0; r < 2; r++) begin
      fill_rand();
      send_row(4, 1'b0);
    end
    drain("t1_drain", 60);
    check("t1_frame_done_count", fd_count, 1);
    check("t1_img_idx", img_idx, 1);

    // Image 1: fuse-wins row then new-wins row.
    fill(8'd200, 8'd40, 1);
    send_row(4, 1'b0);
    fill(8'd200, 8'd40, 0);
    send_row(4, 1'b0);
    drain("t2_drain", 60);
    check("t2_img_idx", img_idx, 2);

    // Image 2 row 0: weights 0,FF,0,0; eol must leave without a following row.
    fill(8'd200, 8'd0, 0);
    rm[1] = 1;
    send_row(4, 1'b0);
    drain("t4_eol_exit", 12);
    // Image 2 row 1: opposite denominator signs.
    fill(8'd200, 8'd40, 2);
    send_row(4, 1'b0);
    drain("t3_drain", 60);

    // Images 3..5: random backpressure and input gaps.
    rand_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      fill_rand();
      send_row(4, 1'b1);
    end
    drain("t5_drain", 200);
    check("t5_frame_done_count", fd_count, 6);
    check("t5_img_idx", img_idx, 6);

    // Reset part-way through row 1.
    fill_rand();
    send_row(4, 1'b0);
    fill_rand();
    send_row(2, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("t6_m_valid", m_valid, 0);
    check("t6_img_idx", img_idx, 0);
    check("t6_frame_done", frame_done, 0);
    exp_q.delete();
    bimg    = 0;
    brow    = 0;
    out_img = 0;
    idle(2);
    rst = 1'b1;
    idle(1);
    for (int r = 0; r < 2; r++) begin
      fill_rand();
      send_row(4, 1'b0);
    end
    drain("t6_drain", 60);
    check("t6_img_idx_after", img_idx, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
